mul_seq_ctrl: RTL and testbench

- Multi-cycle shift-add multiply sequencer for the `mul` funct (ALUControl 4'b1001) in the EX stage.
- Removes the single-cycle 32x32 multiplier from the ALU critical path.
- Accepts operands when EX issues a MUL and holds the pipeline via Stall while iterating.
- Presents the low WIDTH bits of the product with a one-cycle Done pulse, when the pipeline advances.

---
 rtl/mul_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_mul_seq_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: multi-cycle shift-add sequencer for the MUL instruction in EX.
// Retires STEP multiplier bits per cycle and holds the pipeline via Stall
// while iterating. The low WIDTH bits of OpA*OpB appear on Result together
// with a one-cycle Done pulse in the cycle the pipeline is released.
// Optional feature: define MUL_EARLY_EXIT_EN to finish as soon as the
// remaining multiplier bits are all zero.
module mul_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Flush,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    output logic             Stall,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result
);

    localparam int ITERS = WIDTH / STEP;
    localparam int CW    = $clog2(ITERS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_reg,  state_next;
    logic [WIDTH-1:0]  acc_reg,    acc_next;
    logic [WIDTH-1:0]  mcand_reg,  mcand_next;
    logic [WIDTH-1:0]  mplier_reg, mplier_next;
    logic [CW-1:0]     count_reg,  count_next;
    logic [WIDTH-1:0]  result_reg, result_next;
    logic              busy_reg,   busy_next;
    logic              done_reg,   done_next;

    // Partial product of mcand and the low STEP multiplier bits, built as a
    // chain of conditional shifted adds (truncated to WIDTH bits).
    logic [WIDTH-1:0]  pp_sum [STEP+1];
    assign pp_sum[0] = '0;

    generate
        for (genvar gi = 0; gi < STEP; gi++) begin : g_pp
            assign pp_sum[gi+1] = pp_sum[gi] +
                                  (mplier_reg[gi] ? (mcand_reg << gi) : '0);
        end
    endgenerate

    logic [WIDTH-1:0]  acc_step;
    logic [WIDTH-1:0]  mcand_shift;
    logic [WIDTH-1:0]  mplier_shift;
    logic              last_iter;

    assign acc_step     = acc_reg + pp_sum[STEP];
    assign mcand_shift  = mcand_reg << STEP;
    assign mplier_shift = mplier_reg >> STEP;

`ifdef MUL_EARLY_EXIT_EN
    // Stop once no set multiplier bits remain; the counter still bounds it.
    assign last_iter = (count_reg == CW'(1)) || (mplier_shift == '0);
`else
    assign last_iter = (count_reg == CW'(1));
`endif

    // State and datapath registers; reset wins over everything.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg  <= S_IDLE;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
            result_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            count_reg  <= count_next;
            result_reg <= result_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    // Next-state, datapath update and the combinational Stall.
    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        count_next  = count_reg;
        result_next = result_reg;
        Stall       = 1'b0;
        busy_next   = 1'b0;
        done_next   = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (Start && !Flush) begin
                    Stall       = 1'b1;
                    mcand_next  = OpA;
                    mplier_next = OpB;
                    acc_next    = '0;
                    count_next  = CW'(ITERS);
                    state_next  = S_RUN;
                end
            end
            S_RUN: begin
                Stall = 1'b1;
                if (Flush) begin
                    // Squashed instruction: abandon without touching Result.
                    state_next = S_IDLE;
                end else begin
                    acc_next    = acc_step;
                    mcand_next  = mcand_shift;
                    mplier_next = mplier_shift;
                    count_next  = count_reg - CW'(1);
                    if (last_iter) begin
                        result_next = acc_step;
                        state_next  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // The finished MUL still holds Start high; do not re-accept.
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        busy_next = (state_next != S_IDLE);
        done_next = (state_next == S_DONE);
    end

    assign Busy   = busy_reg;
    assign Done   = done_reg;
    assign Result = result_reg;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Testbench for mul_seq_ctrl: instance 0 uses STEP=1, instance 1 STEP=2.
// Expected products come from plain multiplication, expected latency from
// the cycle-count rule (fixed, or chunk count when MUL_EARLY_EXIT_EN is set).
module tb_mul_seq_ctrl;

    logic        Clk;
    logic        Reset;
    logic        start_s [2];
    logic        flush_s [2];
    logic [31:0] opa_s   [2];
    logic [31:0] opb_s   [2];
    logic        stall_o [2];
    logic        busy_o  [2];
    logic        done_o  [2];
    logic [31:0] res_o   [2];

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_res [2];

    mul_seq_ctrl #(.WIDTH(32), .STEP(1)) dut0 (
        .Clk(Clk), .Reset(Reset), .Start(start_s[0]), .Flush(flush_s[0]),
        .OpA(opa_s[0]), .OpB(opb_s[0]), .Stall(stall_o[0]), .Busy(busy_o[0]),
        .Done(done_o[0]), .Result(res_o[0])
    );

    mul_seq_ctrl #(.WIDTH(32), .STEP(2)) dut1 (
        .Clk(Clk), .Reset(Reset), .Start(start_s[1]), .Flush(flush_s[1]),
        .OpA(opa_s[1]), .OpB(opb_s[1]), .Stall(stall_o[1]), .Busy(busy_o[1]),
        .Done(done_o[1]), .Result(res_o[1])
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int          d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Cycle (counted from the accept cycle 0) in which Done must appear.
    function automatic int exp_lat(input logic [31:0] b, input int step);
`ifdef MUL_EARLY_EXIT_EN
        int msb = -1;
        int k;
        for (int i = 0; i < 32; i++) if (b[i]) msb = i;
        k = (msb + 1 + step - 1) / step;
        if (k < 1) k = 1;
        return k + 1;
`else
        return 32 / step + 1;
`endif
    endfunction

    // One complete MUL: Start held through DONE, dropped the cycle after.
    task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input bit scramble,
                          input bit flush_done, input string name);
        int lat;
        int done_cyc;
        int pulses;
        int stall_bad;
        lat       = exp_lat(b, d + 1);
        done_cyc  = -1;
        pulses    = 0;
        stall_bad = 0;
        @(posedge Clk); #1;
        start_s[d] = 1'b1;
        opa_s[d]   = a;
        opb_s[d]   = b;
        for (int c = 0; c <= lat + 2; c++) begin
            if (c == lat + 1) start_s[d] = 1'b0;
            if (c == lat) flush_s[d] = flush_done;
            if (c > 0 && scramble) begin
                opa_s[d] = $urandom;
                opb_s[d] = $urandom;
            end
            @(negedge Clk);
            if (done_o[d] === 1'b1) begin
                pulses++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (stall_o[d] !== (c < lat)) stall_bad++;
            if (c == lat)     chk({name, "_result"}, res_o[d], exp_res);
            if (c == lat + 1) chk({name, "_busy_after"}, {31'd0, busy_o[d]}, 32'd0);
            if (c == lat + 2) chk({name, "_result_held"}, res_o[d], exp_res);
            @(posedge Clk); #1;
            flush_s[d] = 1'b0;
        end
        chk({name, "_done_cycle"}, done_cyc, lat);
        chk({name, "_done_pulses"}, pulses, 32'd1);
        chk({name, "_stall_profile"}, stall_bad, 32'd0);
        last_res[d] = exp_res;
        $display("op %s dut%0d a=%h b=%h exp=%h done_cycle=%0d exp_cycle=%0d",
                 name, d, a, b, exp_res, done_cyc, lat);
    endtask

    vec_t vecs [8];

    initial begin
        int lat;
        int fc;
        logic [31:0] ra;
        logic [31:0] rb;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0; flush_s[i] = 1'b0; opa_s[i] = '0; opb_s[i] = '0;
            last_res[i] = '0;
        end
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;

        vecs[0] = '{0, 32'd7,        32'd6,        32'h0000002A};
        vecs[1] = '{0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1};
        vecs[2] = '{0, 32'h00010000, 32'h00010000, 32'h00000000};
        vecs[3] = '{0, 32'd7,        32'd1,        32'd7};
        vecs[4] = '{0, 32'd7,        32'd0,        32'd0};
        vecs[5] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1};
        vecs[6] = '{1, 32'h12345678, 32'd3,        32'h369D0368};
        vecs[7] = '{1, 32'hFFFFFFFD, 32'h80000001, 32'h7FFFFFFD};

        // Reset state
        @(negedge Clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_busy",   {31'd0, busy_o[i]},  32'd0);
            chk("reset_done",   {31'd0, done_o[i]},  32'd0);
            chk("reset_stall",  {31'd0, stall_o[i]}, 32'd0);
            chk("reset_result", res_o[i],            32'd0);
        end

        // Directed vector table
        foreach (vecs[i])
            run_op(vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].res, 1'b0, 1'b0, $sformatf("vec%0d", i));

        // Flush in DONE has no effect on the Done pulse
        run_op(0, 32'd11, 32'd13, 32'd143, 1'b0, 1'b1, "flush_in_done");

        // Flush mid-RUN: no Done, Busy drops, Result keeps the old value
        lat = exp_lat(32'd3, 1);
        fc  = (lat - 1 < 10) ? lat - 1 : 10;
        @(posedge Clk); #1;
        start_s[0] = 1'b1; opa_s[0] = 32'd2; opb_s[0] = 32'd3;
        for (int c = 0; c <= fc; c++) begin
            if (c == fc) flush_s[0] = 1'b1;
            @(negedge Clk);
            chk("flush_run_stall", {31'd0, stall_o[0]}, 32'd1);
            chk("flush_run_nodone", {31'd0, done_o[0]}, 32'd0);
            @(posedge Clk); #1;
        end
        flush_s[0] = 1'b0; start_s[0] = 1'b0;
        @(negedge Clk);
        chk("flush_busy",   {31'd0, busy_o[0]},  32'd0);
        chk("flush_done",   {31'd0, done_o[0]},  32'd0);
        chk("flush_stall",  {31'd0, stall_o[0]}, 32'd0);
        chk("flush_result", res_o[0],            last_res[0]);
        $display("op flush_run dut0 flushed in cycle %0d", fc);
        run_op(0, 32'd9, 32'd9, 32'h51, 1'b0, 1'b0, "after_flush");

        // Flush together with Start in IDLE: no accept, no stall
        @(posedge Clk); #1;
        start_s[0] = 1'b1; flush_s[0] = 1'b1; opa_s[0] = 32'd4; opb_s[0] = 32'd4;
        @(negedge Clk);
        chk("idle_flush_stall", {31'd0, stall_o[0]}, 32'd0);
        @(posedge Clk); #1;
        start_s[0] = 1'b0; flush_s[0] = 1'b0;
        @(negedge Clk);
        chk("idle_flush_busy", {31'd0, busy_o[0]}, 32'd0);
        $display("op idle_flush dut0 no accept expected");

        // Reset during RUN (cycle 5)
        @(posedge Clk); #1;
        start_s[0] = 1'b1; opa_s[0] = 32'd5; opb_s[0] = 32'hFFFFFFFF;
        for (int c = 0; c < 5; c++) @(posedge Clk);
        #1 Reset = 1'b1;
        @(posedge Clk); #1 Reset = 1'b0;
        @(negedge Clk);
        chk("rst_run_busy",   {31'd0, busy_o[0]},  32'd0);
        chk("rst_run_done",   {31'd0, done_o[0]},  32'd0);
        chk("rst_run_result", res_o[0],            32'd0);
        chk("rst_run_stall",  {31'd0, stall_o[0]}, 32'd1);
        start_s[0] = 1'b0;
        last_res[0] = '0;
        last_res[1] = '0;
        $display("op reset_in_run dut0 reset in cycle 5");

        // Randomized operations with operands changing after accept
        for (int i = 0; i < 24; i++) begin
            int d;
            d  = i % 2;
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_op(d, ra, rb, ra * rb, 1'b1, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
